mmio_uart_responder: RTL

- Memory-mapped I/O responder on the processor's data-memory bus. It sits beside the data RAM and answers the same MemRead/MemWrite/Address/WriteData/ReadData transactions.
- Provides a 32-bit output port register, a synchronized 8-bit input port, and a UART 8N1 transmitter fed by a small TX FIFO.
- Lets a program running on the core drive PortOut and send serial bytes with plain sw/lw.

---
 rtl/mmio_uart_pkg.sv | 26 ++
 rtl/mmio_tx_fifo.sv | 60 ++++++
 rtl/mmio_uart_responder.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the MMIO UART responder: register offsets, STATUS
// bit positions and the TX state encoding.
package mmio_uart_pkg;

    // Word offsets (Address[3:2]) inside the 16-byte register window
    localparam logic [1:0] OFF_PORT_OUT = 2'd0;
    localparam logic [1:0] OFF_PORT_IN  = 2'd1;
    localparam logic [1:0] OFF_TX_DATA  = 2'd2;
    localparam logic [1:0] OFF_STATUS   = 2'd3;

    // STATUS register bit positions
    localparam int unsigned STAT_TX_BUSY    = 0;
    localparam int unsigned STAT_FIFO_FULL  = 1;
    localparam int unsigned STAT_FIFO_EMPTY = 2;
    localparam int unsigned STAT_OVERFLOW   = 3;
    localparam int unsigned STAT_W          = 4;

    // UART transmitter states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/mmio_tx_fifo.sv
// Small synchronous FIFO feeding the UART transmitter.
// Ports: clk, rst_n (async, active-low); push/push_data write side (dropped
// when full); pop/pop_data read side (pop_data is the head entry, valid when
// not empty); full, empty and count describe the occupancy.
module mmio_tx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               pop_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             push_ok;
    logic             pop_ok;

    // A push while full is dropped even if a pop frees a slot on the same edge
    assign push_ok  = push & ~full;
    assign pop_ok   = pop & ~empty;
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/mmio_uart_responder.sv
// Memory-mapped I/O responder on the data-memory bus: 32-bit output port,
// synchronized 8-bit input port and an 8N1 UART transmitter behind a TX FIFO.
// Ports: clk, reset (async, active-low); MemWrite/MemRead/Address/WriteData
// bus request; ReadData combinational read data (0 when not selected);
// PortIn external pins; PortOut registered output port; uart_tx serial line.
module mmio_uart_responder
    import mmio_uart_pkg::*;
#(
    parameter logic [31:0] IO_BASE      = 32'hFFFF_0000,
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    input  logic [7:0]  PortIn,
    output logic [31:0] PortOut,
    output logic        uart_tx
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    logic              sel;
    logic [1:0]        offset;
    logic              wr_en;
    logic              push;
    logic              pop;
    logic [7:0]        fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [7:0]        sync1;
    logic [7:0]        sync2;
    logic              overflow;
    tx_state_e         state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift;
    logic              baud_last;
    logic [STAT_W-1:0] status;
    logic              unused_bits;

    // Byte lanes are ignored and the FIFO count is not exposed on the bus
    assign unused_bits = ^{Address[1:0], fifo_count};

    // Bus decode
    assign sel    = (Address[31:4] == IO_BASE[31:4]);
    assign offset = Address[3:2];
    assign wr_en  = MemWrite & sel;
    assign push   = wr_en & (offset == OFF_TX_DATA);

    assign baud_last = (baud_cnt == BAUD_LAST);

    // FIFO is drained when idle or on the last stop-bit cycle (back-to-back frames)
    assign pop = ~fifo_empty & ((state == IDLE) | ((state == STOP) & baud_last));

    always_comb begin
        status                  = '0;
        status[STAT_TX_BUSY]    = (state != IDLE);
        status[STAT_FIFO_FULL]  = fifo_full;
        status[STAT_FIFO_EMPTY] = fifo_empty;
        status[STAT_OVERFLOW]   = overflow;
    end

    // Same-cycle read mux, like the data RAM
    always_comb begin
        ReadData = 32'h0;
        if (MemRead && sel) begin
            case (offset)
                OFF_PORT_OUT: ReadData = PortOut;
                OFF_PORT_IN:  ReadData = {24'h0, sync2};
                OFF_TX_DATA:  ReadData = 32'h0;
                OFF_STATUS:   ReadData = {{(32 - STAT_W){1'b0}}, status};
                default:      ReadData = 32'h0;
            endcase
        end
    end

    // Output port, input synchronizer and sticky overflow flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PortOut  <= 32'h0;
            sync1    <= 8'h0;
            sync2    <= 8'h0;
            overflow <= 1'b0;
        end else begin
            sync1 <= PortIn;
            sync2 <= sync1;
            if (wr_en && (offset == OFF_PORT_OUT)) begin
                PortOut <= WriteData;
            end
            // A new overflow event wins over a simultaneous clear
            if (push && fifo_full) begin
                overflow <= 1'b1;
            end else if (wr_en && (offset == OFF_STATUS) && WriteData[STAT_OVERFLOW]) begin
                overflow <= 1'b0;
            end
        end
    end

    mmio_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (push),
        .push_data (WriteData[7:0]),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // 8N1 transmitter; uart_tx is registered and updated with each state change
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            uart_tx  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    uart_tx <= 1'b1;
                    if (!fifo_empty) begin
                        shift    <= fifo_head;
                        baud_cnt <= '0;
                        uart_tx  <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        uart_tx  <= shift[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            uart_tx <= 1'b1;
                            state   <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shift   <= {1'b0, shift[7:1]};
                            uart_tx <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (!fifo_empty) begin
                            shift   <= fifo_head;
                            uart_tx <= 1'b0;
                            state   <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                default: begin
                    uart_tx <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
